// File: rtl/sd_arbiter.sv
// SD card host arbiter: shares one SD sector interface between the floppy
// controller (FDC) and the ACSI hard-disk emulation. Requests are held
// levels; the owner is chosen round-robin on a tie, and a stalled request
// is aborted by a saturating timeout counter.
module sd_arbiter #(
    parameter int TIMEOUT_W = 16
) (
    input  logic        clk_32,
    input  logic        reset,
    input  logic [1:0]  fdc_rd,
    input  logic [1:0]  fdc_wr,
    input  logic [31:0] fdc_lba,
    input  logic [7:0]  fdc_din,
    input  logic [1:0]  acsi_rd,
    input  logic [1:0]  acsi_wr,
    input  logic [31:0] acsi_lba,
    input  logic [7:0]  acsi_din,
    output logic [3:0]  sd_rd,
    output logic [3:0]  sd_wr,
    output logic [31:0] sd_lba,
    output logic [7:0]  sd_din,
    input  logic        sd_busy,
    input  logic        sd_done,
    input  logic        sd_dout_strobe,
    output logic        fdc_ack,
    output logic        fdc_done,
    output logic        fdc_strobe,
    output logic        acsi_ack,
    output logic        acsi_done,
    output logic        acsi_strobe,
    output logic        timeout_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER, ST_RELEASE} state_t;
    typedef enum logic {OWN_FDC, OWN_ACSI} owner_t;

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;
    localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t               state, state_nx;
    owner_t               owner, owner_nx;
    owner_t               last,  last_nx;
    logic [TIMEOUT_W-1:0] cnt,   cnt_nx;

    logic fdc_pend, acsi_pend, own_pend;
    logic is_fdc, is_acsi, timed_out;

    assign fdc_pend  = |{fdc_rd, fdc_wr};
    assign acsi_pend = |{acsi_rd, acsi_wr};
    assign is_fdc    = (owner == OWN_FDC);
    assign is_acsi   = (owner == OWN_ACSI);
    assign own_pend  = is_fdc ? fdc_pend : acsi_pend;
    assign timed_out = (state == ST_REQ) && (cnt == CNT_MAX);

    // State, ownership and timeout registers; reset makes FDC win the first tie.
    always_ff @(posedge clk_32 or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            owner <= OWN_FDC;
            last  <= OWN_ACSI;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic: grant, wait for host ack or abort, then one release cycle.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last;
        cnt_nx   = '0;
        case (state)
            ST_IDLE: begin
                if (fdc_pend && acsi_pend) begin
                    owner_nx = (last == OWN_FDC) ? OWN_ACSI : OWN_FDC;
                    state_nx = ST_REQ;
                end else if (fdc_pend) begin
                    owner_nx = OWN_FDC;
                    state_nx = ST_REQ;
                end else if (acsi_pend) begin
                    owner_nx = OWN_ACSI;
                    state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                if (cnt == CNT_MAX) begin
                    last_nx  = owner;
                    state_nx = ST_IDLE;
                end else if (sd_busy) begin
                    last_nx  = owner;
                    state_nx = ST_XFER;
                end else if (!own_pend) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = sat_inc(cnt);
                end
            end
            ST_XFER: begin
                if (!sd_busy) state_nx = ST_RELEASE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Host-side request mux and owner-gated handshakes; non-owner always sees 0.
    always_comb begin
        sd_rd       = 4'b0000;
        sd_wr       = 4'b0000;
        sd_lba      = is_acsi ? acsi_lba : fdc_lba;
        sd_din      = is_acsi ? acsi_din : fdc_din;
        timeout_err = timed_out;
        if ((state == ST_REQ) && !timed_out) begin
            if (is_fdc) begin
                sd_rd = {2'b00, fdc_rd};
                sd_wr = {2'b00, fdc_wr};
            end else begin
                sd_rd = {acsi_rd, 2'b00};
                sd_wr = {acsi_wr, 2'b00};
            end
        end
        fdc_ack     = sd_busy & is_fdc  & ((state == ST_REQ) || (state == ST_XFER));
        acsi_ack    = sd_busy & is_acsi & ((state == ST_REQ) || (state == ST_XFER));
        // sd_done is not state-qualified, so reset must mask it explicitly.
        fdc_done    = sd_done & is_fdc  & ~reset;
        acsi_done   = sd_done & is_acsi & ~reset;
        fdc_strobe  = sd_dout_strobe & is_fdc  & (state == ST_XFER);
        acsi_strobe = sd_dout_strobe & is_acsi & (state == ST_XFER);
    end

endmodule

// File: tb/tb_sd_arbiter.sv
// Bench for sd_arbiter: directed scenarios with literal expectations, then a
// randomized host/requester run, all checked every cycle against a
// behavioural model of the arbitration rules.
module tb_sd_arbiter;

    localparam int TW   = 4;
    localparam int MAXW = (1 << TW) - 1;

    logic        clk_32 = 1'b0;
    logic        reset;
    logic [1:0]  fdc_rd, fdc_wr, acsi_rd, acsi_wr;
    logic [31:0] fdc_lba, acsi_lba;
    logic [7:0]  fdc_din, acsi_din;
    logic [3:0]  sd_rd, sd_wr;
    logic [31:0] sd_lba;
    logic [7:0]  sd_din;
    logic        sd_busy, sd_done, sd_dout_strobe;
    logic        fdc_ack, fdc_done, fdc_strobe;
    logic        acsi_ack, acsi_done, acsi_strobe, timeout_err;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 requesting, 2 transferring, 3 releasing.
    int m_state, m_owner, m_last, m_wait;

    sd_arbiter #(.TIMEOUT_W(TW)) dut (
        .clk_32(clk_32), .reset(reset),
        .fdc_rd(fdc_rd), .fdc_wr(fdc_wr), .fdc_lba(fdc_lba), .fdc_din(fdc_din),
        .acsi_rd(acsi_rd), .acsi_wr(acsi_wr), .acsi_lba(acsi_lba), .acsi_din(acsi_din),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba), .sd_din(sd_din),
        .sd_busy(sd_busy), .sd_done(sd_done), .sd_dout_strobe(sd_dout_strobe),
        .fdc_ack(fdc_ack), .fdc_done(fdc_done), .fdc_strobe(fdc_strobe),
        .acsi_ack(acsi_ack), .acsi_done(acsi_done), .acsi_strobe(acsi_strobe),
        .timeout_err(timeout_err)
    );

    always #5 clk_32 = ~clk_32;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_owner = 0;
        m_last  = 1;
        m_wait  = 0;
    endtask

    // Expected outputs for the current cycle from the model and live inputs.
    task automatic model_check();
        logic [3:0] e_rd, e_wr;
        logic live;
        if (reset) model_reset();
        live = (m_state == 1) && (m_wait < MAXW);
        e_rd = 4'b0000;
        e_wr = 4'b0000;
        if (live) begin
            e_rd = (m_owner == 0) ? {2'b00, fdc_rd} : {acsi_rd, 2'b00};
            e_wr = (m_owner == 0) ? {2'b00, fdc_wr} : {acsi_wr, 2'b00};
        end
        chk("m_sd_rd", 32'(sd_rd), 32'(e_rd));
        chk("m_sd_wr", 32'(sd_wr), 32'(e_wr));
        chk("m_timeout_err", 32'(timeout_err), 32'((m_state == 1) && (m_wait == MAXW)));
        chk("m_fdc_ack",  32'(fdc_ack),  32'(sd_busy && m_owner == 0 && (m_state == 1 || m_state == 2)));
        chk("m_acsi_ack", 32'(acsi_ack), 32'(sd_busy && m_owner == 1 && (m_state == 1 || m_state == 2)));
        chk("m_fdc_done",  32'(fdc_done),  32'(sd_done && m_owner == 0 && !reset));
        chk("m_acsi_done", 32'(acsi_done), 32'(sd_done && m_owner == 1 && !reset));
        chk("m_fdc_strobe",  32'(fdc_strobe),  32'(sd_dout_strobe && m_owner == 0 && m_state == 2));
        chk("m_acsi_strobe", 32'(acsi_strobe), 32'(sd_dout_strobe && m_owner == 1 && m_state == 2));
        if (!reset && m_state != 0) begin
            chk("m_sd_lba", sd_lba, (m_owner == 0) ? fdc_lba : acsi_lba);
            chk("m_sd_din", 32'(sd_din), 32'((m_owner == 0) ? fdc_din : acsi_din));
        end
    endtask

    // Advance the model across one rising edge using the inputs present at it.
    task automatic model_update();
        logic fp, ap, op;
        fp = |{fdc_rd, fdc_wr};
        ap = |{acsi_rd, acsi_wr};
        op = (m_owner == 0) ? fp : ap;
        if (reset) begin
            model_reset();
        end else begin
            case (m_state)
                0: if (fp || ap) begin
                    m_owner = (fp && ap) ? (1 - m_last) : (fp ? 0 : 1);
                    m_state = 1;
                    m_wait  = 0;
                end
                1: if (m_wait == MAXW) begin
                    m_last = m_owner; m_state = 0; m_wait = 0;
                end else if (sd_busy) begin
                    m_last = m_owner; m_state = 2; m_wait = 0;
                end else if (!op) begin
                    m_state = 0; m_wait = 0;
                end else begin
                    m_wait++;
                end
                2: if (!sd_busy) m_state = 3;
                default: m_state = 0;
            endcase
        end
    endtask

    // One clock: compare mid-cycle, step the model on the edge, return 1 time unit later.
    task automatic tick();
        @(negedge clk_32);
        model_check();
        @(posedge clk_32);
        model_update();
        #1;
    endtask

    int n, te;
    int h_phase, h_cnt;
    logic fa, aa, sreq;
    logic [3:0] v;

    initial begin
        reset = 1'b0;
        fdc_rd = 0; fdc_wr = 0; acsi_rd = 0; acsi_wr = 0;
        fdc_lba = 0; acsi_lba = 0; fdc_din = 0; acsi_din = 0;
        sd_busy = 0; sd_done = 0; sd_dout_strobe = 0;
        model_reset();
        #1 reset = 1'b1;
        sd_busy = 1; sd_done = 1; sd_dout_strobe = 1;
        #1;
        chk("rst_sd_rd", 32'(sd_rd), 0);
        chk("rst_sd_wr", 32'(sd_wr), 0);
        chk("rst_fdc_ack", 32'(fdc_ack), 0);
        chk("rst_fdc_done", 32'(fdc_done), 0);
        chk("rst_acsi_done", 32'(acsi_done), 0);
        chk("rst_strobe", 32'({fdc_strobe, acsi_strobe}), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        sd_busy = 0; sd_done = 0; sd_dout_strobe = 0;
        tick(); tick();
        reset = 1'b0;

        // Single floppy read with a 20-cycle host transfer.
        fdc_rd = 2'b01; fdc_lba = 32'h10;
        tick();
        chk("a_sd_rd_req", 32'(sd_rd), 32'h1);
        chk("a_sd_lba", sd_lba, 32'h10);
        tick(); tick();
        chk("a_sd_rd_wait", 32'(sd_rd), 32'h1);
        sd_busy = 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (fdc_ack) n++;
            if (i == 0) fdc_rd = 2'b00;
            tick();
        end
        chk("a_ack_cycles", n, 20);
        sd_busy = 0; sd_done = 1;
        #1;
        chk("a_fdc_done", 32'(fdc_done), 1);
        chk("a_acsi_done", 32'(acsi_done), 0);
        tick();
        sd_done = 0;
        tick(); tick();

        // Simultaneous requests straight after reset: FDC first, then ACSI.
        reset = 1; tick(); reset = 0;
        fdc_rd = 2'b01; acsi_rd = 2'b01; fdc_lba = 32'h100; acsi_lba = 32'h200;
        tick();
        chk("b_first_fdc", 32'(sd_rd), 32'h1);
        sd_busy = 1; #1; fdc_rd = 0;
        tick();
        sd_busy = 0;
        tick();
        chk("b_release_gap", 32'(sd_rd), 0);
        tick();
        chk("b_idle_gap", 32'(sd_rd), 0);
        tick();
        chk("b_then_acsi", 32'(sd_rd), 32'h4);
        chk("b_acsi_lba", sd_lba, 32'h200);
        sd_busy = 1; #1; acsi_rd = 0;
        tick();
        sd_busy = 0;
        tick(); tick(); tick();

        // ACSI write data mux; floppy request waits for the transfer to end.
        acsi_wr = 2'b01; acsi_din = 8'hA5; fdc_din = 8'h3C;
        tick();
        chk("c_sd_wr", 32'(sd_wr), 32'h4);
        sd_busy = 1; #1; acsi_wr = 0;
        tick();
        chk("c_sd_din", 32'(sd_din), 32'hA5);
        fdc_rd = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("c_fdc_ack_blocked", 32'(fdc_ack), 0);
            tick();
        end
        sd_busy = 0;
        tick();
        chk("c_fdc_ack_release", 32'(fdc_ack), 0);
        tick();
        chk("c_idle_gap", 32'(sd_rd), 0);
        tick();
        chk("c_fdc_served", 32'(sd_rd), 32'h1);
        sd_busy = 1; #1;
        chk("c_fdc_ack", 32'(fdc_ack), 1);
        fdc_rd = 0;
        tick();
        sd_busy = 0;
        tick(); tick();

        // ACSI write the host never acknowledges.
        acsi_wr = 2'b10;
        n = 0; te = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sd_wr == 4'b1000) n++;
            if (timeout_err) begin
                te++;
                acsi_wr = 0;
            end
        end
        chk("d_req_cycles", n, 15);
        chk("d_timeout_pulses", te, 1);
        chk("d_idle_after", 32'(sd_wr), 0);

        // Reset in the middle of a transfer.
        fdc_wr = 2'b01;
        tick();
        sd_busy = 1; #1; fdc_wr = 0;
        tick();
        chk("e_ack_before", 32'(fdc_ack), 1);
        reset = 1;
        #1;
        chk("e_sd_rd", 32'(sd_rd), 0);
        chk("e_sd_wr", 32'(sd_wr), 0);
        chk("e_fdc_ack", 32'(fdc_ack), 0);
        chk("e_acsi_ack", 32'(acsi_ack), 0);
        tick();
        reset = 0; sd_busy = 0; fdc_rd = 2'b10;
        tick();
        chk("e_restart", 32'(sd_rd), 32'h2);
        sd_busy = 1; #1; fdc_rd = 0;
        tick();
        sd_busy = 0;
        tick(); tick();

        // Randomized host and requesters.
        h_phase = 0; h_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            fa = fdc_ack; aa = acsi_ack; sreq = |{sd_rd, sd_wr};
            sd_done = 0; sd_dout_strobe = 0;
            reset = (c == 1500 || c == 1501);
            case (h_phase)
                0: if (sreq) begin
                    if ($urandom_range(0, 4) == 0) begin h_phase = 4; h_cnt = 20; end
                    else begin h_phase = 1; h_cnt = int'($urandom_range(0, 3)); end
                end else if ($urandom_range(0, 49) == 0) begin
                    sd_busy = 1; h_phase = 5;
                end
                1: if (h_cnt == 0) begin
                    sd_busy = 1; h_phase = 2; h_cnt = int'($urandom_range(1, 6));
                end else h_cnt--;
                2: begin
                    sd_dout_strobe = 1'($urandom_range(0, 1));
                    if (h_cnt == 0) begin
                        sd_busy = 0; sd_dout_strobe = 0; sd_done = 1; h_phase = 0;
                    end else h_cnt--;
                end
                4: if (h_cnt == 0) h_phase = 0; else h_cnt--;
                default: begin sd_busy = 0; h_phase = 0; end
            endcase
            if (fa) begin
                fdc_rd = 0; fdc_wr = 0;
            end else if (!(|{fdc_rd, fdc_wr})) begin
                if ($urandom_range(0, 3) == 0) begin
                    v = 4'($urandom_range(1, 15));
                    fdc_rd = v[1:0]; fdc_wr = v[3:2]; fdc_lba = $urandom;
                end
            end else if ($urandom_range(0, 39) == 0) begin
                fdc_rd = 0; fdc_wr = 0;
            end
            if (aa) begin
                acsi_rd = 0; acsi_wr = 0;
            end else if (!(|{acsi_rd, acsi_wr})) begin
                if ($urandom_range(0, 3) == 0) begin
                    v = 4'($urandom_range(1, 15));
                    acsi_rd = v[1:0]; acsi_wr = v[3:2]; acsi_lba = $urandom;
                end
            end else if ($urandom_range(0, 39) == 0) begin
                acsi_rd = 0; acsi_wr = 0;
            end
            fdc_din  = 8'($urandom);
            acsi_din = 8'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
